alu_wb_buffer: RTL

ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

---
 rtl/alu_wb_buffer_pkg.sv | 27 ++
 rtl/alu_wb_buffer_ram.sv | 26 ++
 rtl/alu_wb_buffer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_wb_buffer_pkg.sv
// Shared backend definitions for the ALU writeback buffer: datapath widths,
// the buffered entry record and small helpers used when packing entries.
package alu_wb_buffer_pkg;

    localparam int XLEN           = 64;
    localparam int PREG_WIDTH_DEF = 6;
    localparam int ROB_WIDTH_DEF  = 6;

    // One buffered ALU result at the default backend widths.
    typedef struct packed {
        logic [XLEN-1:0]           result;
        logic [PREG_WIDTH_DEF-1:0] prd;
        logic                      need_to_wb;
        logic [ROB_WIDTH_DEF-1:0]  robidx;
    } wb_entry_t;

    // Bits needed to store one entry for the given register/ROB index widths.
    function automatic int entry_width(input int preg_w, input int rob_w);
        return XLEN + preg_w + 1 + rob_w;
    endfunction

    // Physical register 0 is hardwired, so a result aimed at it never writes back.
    function automatic logic effective_need(input logic need, input logic prd_is_zero);
        return need & ~prd_is_zero;
    endfunction

endpackage

// File: rtl/alu_wb_buffer_ram.sv
// Entry storage for the writeback buffer: one synchronous write port,
// one asynchronous read port, contents deliberately left unreset.
module wb_entry_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 77
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Capture the incoming entry at the write pointer.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_wb_buffer.sv
// ALU result writeback buffer: a small circular FIFO between the ALU and the
// register-file writeback port, with flush, sticky overflow detection and
// zero-masked outputs whenever nothing is offered.
module alu_wb_buffer
    import alu_wb_buffer_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int PREG_WIDTH = 6,
    parameter int ROB_WIDTH  = 6
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [63:0]                    in_result,
    input  logic [PREG_WIDTH-1:0]          in_prd,
    input  logic                           in_need_to_wb,
    input  logic [ROB_WIDTH-1:0]           in_robidx,
    input  logic                           flush_valid,
    output logic                           wb_valid,
    input  logic                           wb_ready,
    output logic [63:0]                    wb_result,
    output logic [PREG_WIDTH-1:0]          wb_prd,
    output logic                           wb_need_to_wb,
    output logic [ROB_WIDTH-1:0]           wb_robidx,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = entry_width(PREG_WIDTH, ROB_WIDTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic          push;
    logic          pop;
    logic          full;
    logic          not_empty;
    logic [EW-1:0] wr_data;
    logic [EW-1:0] rd_data;

    logic [63:0]            head_result;
    logic [PREG_WIDTH-1:0]  head_prd;
    logic                   head_need;
    logic [ROB_WIDTH-1:0]   head_robidx;

    assign full      = (count_q == FULL_COUNT);
    assign not_empty = (count_q != {CW{1'b0}});
    assign in_ready  = ~full & ~flush_valid;
    assign wb_valid  = not_empty & ~flush_valid;
    assign push      = in_valid & in_ready;
    assign pop       = wb_valid & wb_ready;

    assign wr_data = {in_result, in_prd, in_need_to_wb, in_robidx};
    assign {head_result, head_prd, head_need, head_robidx} = rd_data;

    wb_entry_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Present the head entry, zeroed when nothing is offered and with
    // need_to_wb suppressed for register 0.
    always_comb begin
        wb_result     = 64'd0;
        wb_prd        = {PREG_WIDTH{1'b0}};
        wb_need_to_wb = 1'b0;
        wb_robidx     = {ROB_WIDTH{1'b0}};
        if (wb_valid) begin
            wb_result     = head_result;
            wb_prd        = head_prd;
            wb_need_to_wb = effective_need(head_need, head_prd == {PREG_WIDTH{1'b0}});
            wb_robidx     = head_robidx;
        end else begin
            wb_result     = 64'd0;
            wb_prd        = {PREG_WIDTH{1'b0}};
            wb_need_to_wb = 1'b0;
            wb_robidx     = {ROB_WIDTH{1'b0}};
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the buffer outright.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= {PW{1'b0}};
            rd_ptr  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else if (flush_valid) begin
            wr_ptr  <= {PW{1'b0}};
            rd_ptr  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky record of any push offered while the buffer could not take it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (in_valid & ~in_ready & ~flush_valid) begin
            overflow_q <= 1'b1;
        end
    end

    assign count        = count_q;
    assign overflow_err = overflow_q;

endmodule
